// File: rtl/div_in_packer_if.sv
// Byte-in / operand-out bundle for div_in_packer: a byte source drives the
// push strobe and mode bits, the divider core sees the assembled operand pair.
interface div_in_packer_if #(
  parameter int WIDTH  = 32,
  parameter int BYTE_W = 8
);
  logic [BYTE_W-1:0] data_in_in;
  logic              push_in;
  logic              sign;
  logic              select;
  // Operand handshake: one pair moves on every cycle with op_valid && op_ready.
  // Once op_valid is high it stays high, with all op_* stable, until op_ready.
  logic              op_valid;
  logic              op_ready;
  logic [WIDTH-1:0]  op_dividend;
  logic [WIDTH-1:0]  op_divisor;
  logic              op_sign;
  logic              op_select;
  logic              op_div_zero;
  logic              overflow;
  logic              frame_err;
  logic [1:0]        fsm_state;

  modport master (
    output data_in_in, push_in, sign, select, op_ready,
    input  op_valid, op_dividend, op_divisor, op_sign, op_select,
           op_div_zero, overflow, frame_err, fsm_state
  );

  modport slave (
    input  data_in_in, push_in, sign, select, op_ready,
    output op_valid, op_dividend, op_divisor, op_sign, op_select,
           op_div_zero, overflow, frame_err, fsm_state
  );
endinterface

// File: rtl/div_in_packer.sv
// Byte-serial front end of the srt2 divider: packs dividend then divisor bytes
// into one operand pair. Optional frame timeout: DIV_IN_PACKER_TIMEOUT_EN.
module div_in_packer #(
  parameter int WIDTH          = 32,
  parameter int BYTE_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  div_in_packer_if.slave bus
);
  localparam int NBYTES = 2 * WIDTH / BYTE_W;
  localparam int OPB    = WIDTH / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES);

  if (((WIDTH % BYTE_W) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
    $error("div_in_packer: WIDTH must be a multiple of BYTE_W and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   count_q, count_nxt;
  logic [CNT_W-1:0]   slot;
  logic               push_q;
  logic               accept;
  logic               wr_en;
  logic               frame_done;
  logic               drop;
  logic               timeout_hit;
  logic               frame_err_int;
  logic [WIDTH-1:0]   dividend_q, divisor_q;
  logic [WIDTH-1:0]   dividend_nxt, divisor_nxt;
  logic               sign_q, select_q, div_zero_q, overflow_q;

  // A held strobe yields one byte: accept only on its rising edge.
  assign accept = bus.push_in & ~push_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count_q;
    slot       = '0;
    wr_en      = 1'b0;
    frame_done = 1'b0;
    drop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_en     = 1'b1;
          count_nxt = CNT_W'(1);
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          wr_en = 1'b1;
          slot  = count_q;
          if (count_q == CNT_W'(NBYTES - 1)) begin
            frame_done = 1'b1;
            count_nxt  = '0;
            state_nxt  = HOLD;
          end else begin
            count_nxt = count_q + CNT_W'(1);
          end
        end else if (timeout_hit) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (bus.op_ready) begin
          // A byte arriving with the transfer opens the next frame at slot 0.
          if (accept) begin
            wr_en     = 1'b1;
            count_nxt = CNT_W'(1);
            state_nxt = COLLECT;
          end else begin
            count_nxt = '0;
            state_nxt = IDLE;
          end
        end else if (accept) begin
          drop = 1'b1;
        end
      end
      default: begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Byte steering: slots 0..OPB-1 fill the dividend MSB first, the rest the divisor.
  always_comb begin
    dividend_nxt = dividend_q;
    divisor_nxt  = divisor_q;
    for (int k = 0; k < OPB; k++) begin
      if (wr_en && (slot == CNT_W'(k)))
        dividend_nxt[WIDTH-1-BYTE_W*k -: BYTE_W] = bus.data_in_in;
      if (wr_en && (slot == CNT_W'(k + OPB)))
        divisor_nxt[WIDTH-1-BYTE_W*k -: BYTE_W] = bus.data_in_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sign_q     <= 1'b0;
      select_q   <= 1'b0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      push_q <= bus.push_in;
      if (wr_en) begin
        dividend_q <= dividend_nxt;
        divisor_q  <= divisor_nxt;
      end
      if (frame_done) begin
        sign_q     <= bus.sign;
        select_q   <= bus.select;
        div_zero_q <= (divisor_nxt == '0);
      end
      if (drop)
        overflow_q <= 1'b1;
    end
  end

`ifdef DIV_IN_PACKER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             frame_err_q;
  logic             abort;

  assign timeout_hit = (state_q == COLLECT) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  // A byte landing on the timeout cycle keeps the frame alive.
  assign abort       = timeout_hit & ~accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      tmo_q       <= ((state_q != COLLECT) || accept || abort) ? '0 : tmo_q + TMO_W'(1);
      frame_err_q <= abort;
    end
  end

  assign frame_err_int = frame_err_q;
`else
  assign timeout_hit   = 1'b0;
  assign frame_err_int = 1'b0;
`endif

  always_comb begin
    bus.op_valid    = (state_q == HOLD);
    bus.op_div_zero = div_zero_q & (state_q == HOLD);
    bus.op_dividend = dividend_q;
    bus.op_divisor  = divisor_q;
    bus.op_sign     = sign_q;
    bus.op_select   = select_q;
    bus.overflow    = overflow_q;
    bus.frame_err   = frame_err_int;
    bus.fsm_state   = state_q;
  end
endmodule

// File: tb/tb_div_in_packer.sv
// Self-checking bench for div_in_packer: directed scenarios plus randomized
// frames compared against a byte-list reference model.
module tb_div_in_packer;
  localparam int WIDTH  = 32;
  localparam int BYTE_W = 8;
`ifdef DIV_IN_PACKER_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  typedef logic [2*WIDTH+1:0] frame_t;  // {sign, select, dividend, divisor}

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  frame_t     exp_q[$];
  logic [7:0] fb[8];

  always #5 clk = ~clk;

  div_in_packer_if #(.WIDTH(WIDTH), .BYTE_W(BYTE_W)) bus ();

  div_in_packer #(.WIDTH(WIDTH), .BYTE_W(BYTE_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: first four bytes form the dividend, last four the divisor, MSB first.
  function automatic frame_t model_frame(input logic [7:0] b[8], input logic s, input logic sel);
    logic [WIDTH-1:0] dd;
    logic [WIDTH-1:0] dv;
    dd = '0;
    dv = '0;
    for (int i = 0; i < 4; i++) begin
      dd = {dd[WIDTH-9:0], b[i]};
      dv = {dv[WIDTH-9:0], b[i+4]};
    end
    return {s, sel, dd, dv};
  endfunction

  function automatic frame_t observed();
    return {bus.op_sign, bus.op_select, bus.op_dividend, bus.op_divisor};
  endfunction

  task automatic push_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    bus.data_in_in = b;
    bus.push_in    = 1'b1;
    repeat (hold) @(negedge clk);
    bus.push_in = 1'b0;
  endtask

  task automatic do_reset();
    bus.push_in  = 1'b0;
    bus.op_ready = 1'b0;
    bus.sign     = 1'b0;
    bus.select   = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 8; i++) fb[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %b exp 0", bus.op_valid); end
    checks++; if (bus.op_dividend !== '0) begin errors++; $display("FAIL reset_op_dividend got %h exp 0", bus.op_dividend); end
    checks++; if (bus.op_divisor !== '0) begin errors++; $display("FAIL reset_op_divisor got %h exp 0", bus.op_divisor); end
    checks++; if ({bus.op_sign, bus.op_select, bus.op_div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {bus.op_sign, bus.op_select, bus.op_div_zero}); end
    checks++; if ({bus.overflow, bus.frame_err} !== 2'b00) begin errors++; $display("FAIL reset_status got %b exp 00", {bus.overflow, bus.frame_err}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    frame_t e;
    do_reset();
    bus.op_ready = 1'b1;
    fb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 7; i++) push_byte(fb[i], 1);
    exp_q.push_back(model_frame(fb, 1'b0, 1'b0));
    @(negedge clk);
    bus.data_in_in = fb[7];
    bus.push_in    = 1'b1;
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL unsigned_early_valid got %b exp 0", bus.op_valid); end
    @(negedge clk);
    bus.push_in = 1'b0;
    e = exp_q.pop_front();
    checks++; if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL unsigned_valid got %b exp 1", bus.op_valid); end
    checks++; if (observed() !== e) begin errors++; $display("FAIL unsigned_frame got %h exp %h", observed(), e); end
    checks++; if (bus.op_div_zero !== 1'b0) begin errors++; $display("FAIL unsigned_div_zero got %b exp 0", bus.op_div_zero); end
    @(negedge clk);
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL unsigned_valid_drop got %b exp 0", bus.op_valid); end
    bus.op_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    frame_t e;
    do_reset();
    rand_bytes();
    bus.sign   = 1'b1;
    bus.select = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(fb[i], 1);
    e = model_frame(fb, 1'b1, 1'b1);
    checks++; if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", bus.op_valid); end
    push_byte(~fb[0], 1);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b exp 1", bus.overflow); end
    checks++; if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held got %b exp 1", bus.op_valid); end
    checks++; if (observed() !== e) begin errors++; $display("FAIL bp_frame_stable got %h exp %h", observed(), e); end
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer got %b exp 0", bus.op_valid); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky got %b exp 1", bus.overflow); end
  endtask

  task automatic test_zero_div();
    frame_t e;
    do_reset();
    bus.op_ready = 1'b1;
    fb = '{8'h80, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) begin
      bus.sign   = i[0];
      bus.select = ~i[0];
      push_byte(fb[i], 1);
    end
    bus.sign   = 1'b1;
    bus.select = 1'b0;
    push_byte(fb[7], 1);
    e = model_frame(fb, 1'b1, 1'b0);
    checks++; if (observed() !== e) begin errors++; $display("FAIL zero_frame got %h exp %h", observed(), e); end
    checks++; if (bus.op_div_zero !== 1'b1) begin errors++; $display("FAIL zero_div_zero got %b exp 1", bus.op_div_zero); end
    @(negedge clk);
    checks++; if ({bus.op_valid, bus.op_div_zero} !== 2'b00) begin errors++; $display("FAIL zero_after got %b exp 00", {bus.op_valid, bus.op_div_zero}); end
    bus.op_ready = 1'b0;
  endtask

  task automatic test_long_push_reset();
    frame_t e;
    do_reset();
    rand_bytes();
    fb[4]    = 8'hA5;
    bus.sign = 1'b1;
    push_byte(fb[0], 5);
    for (int i = 1; i < 8; i++) push_byte(fb[i], 1);
    e = model_frame(fb, 1'b1, 1'b0);
    checks++; if ((bus.op_valid !== 1'b1) || (observed() !== e)) begin errors++; $display("FAIL long_push got v=%b %h exp v=1 %h", bus.op_valid, observed(), e); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.op_valid, bus.op_sign, bus.op_dividend, bus.op_divisor} !== '0) begin errors++; $display("FAIL async_reset_hold got v=%b %h exp all zero", bus.op_valid, observed()); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(8'hFF, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({bus.op_valid, bus.op_dividend} !== '0) begin errors++; $display("FAIL async_reset_mid got v=%b dd=%h exp zero", bus.op_valid, bus.op_dividend); end
    @(negedge clk);
    rst_n = 1'b1;
    rand_bytes();
    bus.sign = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(fb[i], 1);
    e = model_frame(fb, 1'b0, 1'b0);
    checks++; if ((bus.op_valid !== 1'b1) || (observed() !== e)) begin errors++; $display("FAIL fresh_frame got v=%b %h exp v=1 %h", bus.op_valid, observed(), e); end
  endtask

  task automatic test_back_to_back();
    frame_t e;
    logic [7:0] f1[8];
    do_reset();
    rand_bytes();
    f1 = fb;
    for (int i = 0; i < 8; i++) push_byte(f1[i], 1);
    e = model_frame(f1, 1'b0, 1'b0);
    checks++; if ((bus.op_valid !== 1'b1) || (observed() !== e)) begin errors++; $display("FAIL b2b_frame1 got v=%b %h exp v=1 %h", bus.op_valid, observed(), e); end
    rand_bytes();
    @(negedge clk);
    bus.op_ready   = 1'b1;
    bus.data_in_in = fb[0];
    bus.push_in    = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    bus.push_in  = 1'b0;
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL b2b_transfer got %b exp 0", bus.op_valid); end
    bus.select = 1'b1;
    for (int i = 1; i < 8; i++) push_byte(fb[i], 1);
    e = model_frame(fb, 1'b0, 1'b1);
    checks++; if ((bus.op_valid !== 1'b1) || (observed() !== e)) begin errors++; $display("FAIL b2b_frame2 got v=%b %h exp v=1 %h", bus.op_valid, observed(), e); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b exp 0", bus.overflow); end
  endtask

  task automatic test_random();
    frame_t e;
    logic s, sel;
    do_reset();
    for (int f = 0; f < 20; f++) begin
      rand_bytes();
      if ($urandom_range(0, 3) == 0) for (int i = 4; i < 8; i++) fb[i] = 8'h00;
      for (int i = 0; i < 8; i++) begin
        s   = 1'($urandom_range(0, 1));
        sel = 1'($urandom_range(0, 1));
        bus.sign   = s;
        bus.select = sel;
        push_byte(fb[i], $urandom_range(1, 3));
        if (i < 7) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      exp_q.push_back(model_frame(fb, s, sel));
      e = exp_q[0];
      checks++; if ((bus.op_valid !== 1'b1) || (observed() !== e)) begin errors++; $display("FAIL rand_frame f=%0d got v=%b %h exp v=1 %h", f, bus.op_valid, observed(), e); end
      checks++; if (bus.op_div_zero !== (e[WIDTH-1:0] == '0)) begin errors++; $display("FAIL rand_div_zero f=%0d got %b exp %b", f, bus.op_div_zero, (e[WIDTH-1:0] == '0)); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++; if ((bus.op_valid !== 1'b1) || (observed() !== e)) begin errors++; $display("FAIL rand_hold f=%0d got v=%b %h exp v=1 %h", f, bus.op_valid, observed(), e); end
      bus.op_ready = 1'b1;
      @(negedge clk);
      bus.op_ready = 1'b0;
      void'(exp_q.pop_front());
      checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL rand_release f=%0d got %b exp 0", f, bus.op_valid); end
    end
    checks++; if ({bus.overflow, bus.frame_err} !== 2'b00) begin errors++; $display("FAIL rand_status got %b exp 00", {bus.overflow, bus.frame_err}); end
  endtask

`ifdef DIV_IN_PACKER_TIMEOUT_EN
  task automatic test_timeout();
    frame_t e;
    int first_k;
    int pulses;
    bit saw_valid;
    do_reset();
    bus.op_ready = 1'b1;
    first_k   = 0;
    pulses    = 0;
    saw_valid = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'h5A, 1);
    for (int k = 1; k <= 3 * TMO; k++) begin
      @(negedge clk);
      if (bus.frame_err === 1'b1) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
      if (bus.op_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++; if (first_k != TMO) begin errors++; $display("FAIL timeout_at got cycle %0d exp %0d", first_k, TMO); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_pulses got %0d exp 1", pulses); end
    checks++; if (saw_valid) begin errors++; $display("FAIL timeout_valid got 1 exp 0"); end
    rand_bytes();
    bus.op_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(fb[i], 1);
    e = model_frame(fb, 1'b0, 1'b0);
    checks++; if ((bus.op_valid !== 1'b1) || (observed() !== e)) begin errors++; $display("FAIL timeout_next got v=%b %h exp v=1 %h", bus.op_valid, observed(), e); end
  endtask
`else
  task automatic test_no_timeout();
    frame_t e;
    bit saw_err;
    do_reset();
    rand_bytes();
    saw_err = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(fb[i], 1);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.frame_err !== 1'b0) saw_err = 1'b1;
    end
    checks++; if (saw_err) begin errors++; $display("FAIL no_timeout_err got 1 exp 0"); end
    for (int i = 3; i < 8; i++) push_byte(fb[i], 1);
    e = model_frame(fb, 1'b0, 1'b0);
    checks++; if ((bus.op_valid !== 1'b1) || (observed() !== e)) begin errors++; $display("FAIL no_timeout_frame got v=%b %h exp v=1 %h", bus.op_valid, observed(), e); end
  endtask
`endif

  initial begin
    bus.data_in_in = '0;
    bus.push_in    = 1'b0;
    bus.sign       = 1'b0;
    bus.select     = 1'b0;
    bus.op_ready   = 1'b0;
    test_reset();
    test_unsigned();
    test_backpressure();
    test_zero_div();
    test_long_push_reset();
    test_back_to_back();
    test_random();
`ifdef DIV_IN_PACKER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
